// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator side of the sequential ALU en/opcode/done handshake. Incoming
// operation requests are buffered in a small command FIFO and issued to the
// ALU one at a time. Each issue is a single-cycle alu_en pulse. The block
// then waits for alu_done, guarded by a watchdog, and hands the captured
// result back through a valid/ready response port.
//
// Ports:
//   clk, nrst                 rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//   cmd_opcode/cmd_a/cmd_b    command payload (0 add, 1 mul, 2 div, 3 cmp)
//   alu_en                    one-cycle start pulse to the ALU control
//   alu_opcode/alu_a/alu_b    operands, held from pop until the next pop
//   alu_done/alu_result       completion flag and 2*WIDTH result from the ALU
//   rsp_valid/rsp_ready       response handshake
//   rsp_opcode/rsp_result     opcode and result of the completed operation
//   rsp_timeout               response was produced by the watchdog
//   busy                      FSM active or commands still queued
//   err_timeout               sticky watchdog error flag
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_opcode,
   input  logic [WIDTH-1:0]   cmd_a,
   input  logic [WIDTH-1:0]   cmd_b,
   output logic               alu_en,
   output logic [1:0]         alu_opcode,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic               alu_done,
   input  logic [2*WIDTH-1:0] alu_result,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [1:0]         rsp_opcode,
   output logic [2*WIDTH-1:0] rsp_result,
   output logic               rsp_timeout,
   output logic               busy,
   output logic               err_timeout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int EW = 2 + 2 * WIDTH;

   localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
   localparam logic [WW-1:0] TIMEOUT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [EW-1:0]   fifo_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic [EW-1:0]   head;

   logic [WW-1:0]   wd_count;
   logic            wd_clear;
   logic            wd_inc;
   logic            cap_done;
   logic            cap_timeout;
   logic            rsp_clear;

   assign fifo_full  = (count == DEPTH_C);
   assign fifo_empty = (count == '0);

   // cmd_ready is forced low while reset is held so every output reads 0;
   // it comes back as soon as nrst releases because the FIFO is empty.
   assign cmd_ready  = nrst && !fifo_full;

   // A push is refused whenever the FIFO is full, even if the FSM pops in
   // the same cycle, so the full flag never depends on the FSM.
   assign push       = cmd_valid && cmd_ready;
   assign head       = fifo_mem[rd_ptr];
   assign busy       = !((state == IDLE) && fifo_empty);

   // Storage array has no reset; stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the count
   // separates the full and empty cases where the pointers are equal.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // alu_en comes straight from the ISSUE state, which lasts exactly one
   // cycle, so the pulse can never stretch into the ALU's holding state.
   // alu_done only matters in WAIT; the ALU drops it on the edge that
   // samples alu_en, so a done left over from the previous op is never
   // mistaken for completion. Done wins over a coinciding watchdog expiry.
   always_comb begin
      state_next  = state;
      pop         = 1'b0;
      alu_en      = 1'b0;
      wd_clear    = 1'b0;
      wd_inc      = 1'b0;
      cap_done    = 1'b0;
      cap_timeout = 1'b0;
      rsp_clear   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            alu_en     = 1'b1;
            wd_clear   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            wd_inc = 1'b1;
            if (alu_done) begin
               cap_done   = 1'b1;
               state_next = RESP;
            end else if (wd_count == TIMEOUT_LAST) begin
               cap_timeout = 1'b1;
               state_next  = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_clear  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands are loaded only on a pop and otherwise held, because the ALU
   // datapath keeps sampling them in every one of its states.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else if (pop) begin
         {alu_opcode, alu_a, alu_b} <= head;
      end
   end

   // Watchdog counts WAIT cycles; the terminal check looks one step ahead
   // so the abort lands on the TIMEOUT-th WAIT cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wd_count <= '0;
      end else if (wd_clear) begin
         wd_count <= '0;
      end else if (wd_inc) begin
         wd_count <= wd_count + WW'(1);
      end
   end

   // Response registers stay frozen throughout RESP until the consumer
   // takes them; err_timeout is sticky until reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rsp_valid   <= 1'b0;
         rsp_opcode  <= '0;
         rsp_result  <= '0;
         rsp_timeout <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (cap_done) begin
            rsp_valid   <= 1'b1;
            rsp_opcode  <= alu_opcode;
            rsp_result  <= alu_result;
            rsp_timeout <= 1'b0;
         end else if (cap_timeout) begin
            rsp_valid   <= 1'b1;
            rsp_opcode  <= alu_opcode;
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            err_timeout <= 1'b1;
         end else if (rsp_clear) begin
            rsp_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. A behavioural ALU responds to alu_en
// (short ops finish one cycle after the start edge, long ops after sixteen)
// and can be told to hang. Stimulus pushes hand-computed expected responses
// into a queue; an independent monitor pops and compares on every response
// handshake and also watches alu_en pulse width and operand stability.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

   localparam int W = 16;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] res;
      logic        to;
   } exp_t;

   logic          clk;
   logic          nrst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_opcode;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;
   logic          alu_en;
   logic [1:0]    alu_opcode;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic          alu_done;
   logic [2*W-1:0] alu_result;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_opcode;
   logic [2*W-1:0] rsp_result;
   logic          rsp_timeout;
   logic          busy;
   logic          err_timeout;

   int            n_cmp;
   int            n_fail;
   int            cyc;
   int            accept_cyc;
   exp_t          sb[$];
   logic          alu_hang;

   alu_op_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(31)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_opcode  (cmd_opcode),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .alu_en      (alu_en),
      .alu_opcode  (alu_opcode),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_opcode  (rsp_opcode),
      .rsp_result  (rsp_result),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   // Free-running clock and cycle counter used for latency measurements.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: add, mul, div ({rem, quot}) and compare (a < b).
   function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] r;
      case (op)
         2'd0:    r = {16'h0, a} + {16'h0, b};
         2'd1:    r = {16'h0, a} * {16'h0, b};
         2'd2:    r = (b == 16'h0) ? 32'hFFFF_FFFF : {a % b, a / b};
         default: r = {31'h0, (a < b)};
      endcase
      return r;
   endfunction

   // The ALU drops done on the edge that samples alu_en, then raises it
   // after one (short) or sixteen (long) further edges and holds it.
   logic [1:0]  m_op;
   logic [15:0] m_a;
   logic [15:0] m_b;
   int          m_cnt;
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         alu_done   <= 1'b0;
         alu_result <= '0;
         m_cnt      <= 0;
         m_op       <= '0;
         m_a        <= '0;
         m_b        <= '0;
      end else if (alu_en) begin
         alu_done <= 1'b0;
         m_op     <= alu_opcode;
         m_a      <= alu_a;
         m_b      <= alu_b;
         m_cnt    <= (alu_opcode == 2'd1 || alu_opcode == 2'd2) ? 16 : 1;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1 && !alu_hang) begin
            alu_done   <= 1'b1;
            alu_result <= alu_fn(m_op, m_a, m_b);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: alu_en pulse width, operand stability while an op is in
   // flight, and scoreboard comparison on every response handshake.
   logic        prev_en;
   logic        inflight;
   logic [33:0] snap_ops;
   always @(negedge clk) begin
      exp_t e;
      if (!nrst) begin
         prev_en  = 1'b0;
         inflight = 1'b0;
      end else begin
         if (alu_en) begin
            checkOutput("alu_en_single_cycle", {63'h0, prev_en}, 64'h0);
            snap_ops = {alu_opcode, alu_a, alu_b};
            inflight = 1'b1;
         end else if (inflight) begin
            checkOutput("alu_operands_stable", {30'h0, alu_opcode, alu_a, alu_b}, {30'h0, snap_ops});
         end
         if (rsp_valid) inflight = 1'b0;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_response", {63'h0, rsp_valid}, 64'h0);
            end else begin
               e = sb.pop_front();
               checkOutput("rsp_opcode", {62'h0, rsp_opcode}, {62'h0, e.op});
               checkOutput("rsp_result", {32'h0, rsp_result}, {32'h0, e.res});
               checkOutput("rsp_timeout", {63'h0, rsp_timeout}, {63'h0, e.to});
            end
         end
         prev_en = alu_en;
      end
   end

   // Offer one command, wait (bounded) for acceptance, record the accept
   // cycle and queue its expected response.
   task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] exp_res, input logic exp_to);
      exp_t e;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      checkOutput("cmd_accepted", {63'h0, cmd_ready}, 64'h1);
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      e.op  = op;
      e.res = exp_res;
      e.to  = exp_to;
      sb.push_back(e);
      cmd_valid = 1'b0;
   endtask

   task automatic waitRspValid(output int lat);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      checkOutput("rsp_valid_seen", {63'h0, rsp_valid}, 64'h1);
      lat = cyc - accept_cyc;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy && !rsp_valid) break;
      end
      checkOutput("reached_idle", {62'h0, busy, rsp_valid}, 64'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int          lat;
      int          ready_cyc;
      logic [35:0] hold_snap;
      logic        seen_valid;
      logic        seen_en;

      n_cmp      = 0;
      n_fail     = 0;
      accept_cyc = 0;
      nrst       = 1'b0;
      cmd_valid  = 1'b0;
      cmd_opcode = '0;
      cmd_a      = '0;
      cmd_b      = '0;
      rsp_ready  = 1'b1;
      alu_hang   = 1'b0;

      // Reset state: every output low while nrst is held.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_outputs",
                  {59'h0, cmd_ready, alu_en, rsp_valid, busy, err_timeout}, 64'h0);
      checkOutput("reset_data", {14'h0, alu_opcode, alu_a, alu_b, rsp_result[0], rsp_timeout},
                  64'h0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", {62'h0, cmd_ready, busy}, 64'h2);
      @(posedge clk);
      #1;

      // Short op: alu_en after edge 1, done after edge 3, response after edge 4.
      applyStimulus(2'd0, 16'h0003, 16'h0004, 32'h0000_0007, 1'b0);
      waitRspValid(lat);
      checkOutput("add_latency", lat, 64'd4);
      waitIdle();

      // Long op: sixteen iteration states, response after edge 19.
      applyStimulus(2'd1, 16'h0012, 16'h0034, 32'h0000_03A8, 1'b0);
      waitRspValid(lat);
      checkOutput("mul_latency", lat, 64'd19);
      waitIdle();

      // Back-to-back: the mul is popped, then four commands fill the FIFO.
      applyStimulus(2'd1, 16'h0100, 16'h0100, 32'h0001_0000, 1'b0);
      applyStimulus(2'd0, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0);
      applyStimulus(2'd3, 16'h0005, 16'h0009, 32'h0000_0001, 1'b0);
      applyStimulus(2'd2, 16'd100,  16'd7,    32'h0002_000E, 1'b0);
      applyStimulus(2'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
      @(negedge clk);
      checkOutput("fifo_full_ready_low", {63'h0, cmd_ready}, 64'h0);
      applyStimulus(2'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0);
      waitIdle();
      checkOutput("burst_all_responses", sb.size(), 64'd0);

      // Response back-pressure with a second command queued behind it.
      rsp_ready = 1'b0;
      applyStimulus(2'd0, 16'd10, 16'd20, 32'h0000_001E, 1'b0);
      applyStimulus(2'd0, 16'd1,  16'd1,  32'h0000_0002, 1'b0);
      waitRspValid(lat);
      hold_snap = {rsp_valid, rsp_opcode, rsp_result, rsp_timeout};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("rsp_hold_stable", {28'h0, rsp_valid, rsp_opcode, rsp_result, rsp_timeout},
                     {28'h0, hold_snap});
         checkOutput("no_issue_while_held", {63'h0, alu_en}, 64'h0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      ready_cyc = cyc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (alu_en) break;
      end
      checkOutput("issue_resume_gap", cyc - ready_cyc, 64'd2);
      waitIdle();

      // Watchdog: pulse at edge 2, then 31 WAIT cycles -> response after edge 33.
      alu_hang = 1'b1;
      applyStimulus(2'd0, 16'd5, 16'd6, 32'h0000_0000, 1'b1);
      waitRspValid(lat);
      checkOutput("timeout_latency", lat, 64'd33);
      checkOutput("err_timeout_set", {63'h0, err_timeout}, 64'h1);
      waitIdle();
      alu_hang = 1'b0;
      applyStimulus(2'd0, 16'd1, 16'd2, 32'h0000_0003, 1'b0);
      applyStimulus(2'd1, 16'd3, 16'd5, 32'h0000_000F, 1'b0);
      waitIdle();
      checkOutput("err_timeout_sticky", {63'h0, err_timeout}, 64'h1);

      // Reset during a mul WAIT with two commands queued.
      applyStimulus(2'd1, 16'd2, 16'd3, 32'h0000_0006, 1'b0);
      applyStimulus(2'd0, 16'd1, 16'd1, 32'h0000_0002, 1'b0);
      applyStimulus(2'd0, 16'd2, 16'd2, 32'h0000_0004, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      nrst = 1'b0;
      #1;
      checkOutput("midreset_flags",
                  {58'h0, cmd_ready, alu_en, rsp_valid, rsp_timeout, busy, err_timeout}, 64'h0);
      checkOutput("midreset_data", {30'h0, alu_opcode, alu_a, alu_b}, 64'h0);
      checkOutput("midreset_result", {32'h0, rsp_result}, 64'h0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      checkOutput("release_ready_empty", {62'h0, cmd_ready, busy}, 64'h2);
      seen_valid = 1'b0;
      seen_en    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | rsp_valid;
         seen_en    = seen_en | alu_en;
      end
      checkOutput("no_rsp_after_reset", {63'h0, seen_valid}, 64'h0);
      checkOutput("no_issue_after_reset", {63'h0, seen_en}, 64'h0);
      @(posedge clk);
      #1;
      applyStimulus(2'd0, 16'd8, 16'd9, 32'h0000_0011, 1'b0);
      waitRspValid(lat);
      checkOutput("post_reset_latency", lat, 64'd4);
      waitIdle();
      checkOutput("scoreboard_drained", sb.size(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
